// File: rtl/reg_file_sb.sv
// Multi-port register file with write bypass, optional zero register and a reserve/busy scoreboard.
// Reads are combinational, writes land at the next edge; the only backpressure is rsv_ready refusing busy registers.
module reg_file_sb #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         we0,
  input  logic [ADDR_WIDTH-1:0]        waddr0,
  input  logic [DATA_WIDTH-1:0]        wdata0,
  input  logic                         we1,
  input  logic [ADDR_WIDTH-1:0]        waddr1,
  input  logic [DATA_WIDTH-1:0]        wdata1,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic                         rsv_valid,
  input  logic [ADDR_WIDTH-1:0]        rsv_addr,
  output logic                         rsv_ready,
  output logic [NUM_REGS-1:0]          busy_vec,
  output logic                         conflict
);

  // One extra bit so the range check never degenerates to a constant compare.
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(NUM_REGS);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < LIMIT;
  endfunction

  function automatic logic writable(input logic [ADDR_WIDTH-1:0] a);
    return in_range(a) && !(ZERO_REG != 0 && a == '0);
  endfunction

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_nxt;
  logic                  wv0;
  logic                  wv1;

  assign wv0 = we0 && writable(waddr0);
  assign wv1 = we1 && writable(waddr1);

  always_comb begin
    logic [ADDR_WIDTH-1:0] ra;
    ra    = '0;
    rdata = '0;
    rbusy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
      if (in_range(ra)) rbusy[k] = busy_vec[ra];
      if (writable(ra)) begin
        // Port 1 is checked first so the bypass matches what the edge will store.
        if (BYPASS != 0 && wv1 && waddr1 == ra)
          rdata[k*DATA_WIDTH +: DATA_WIDTH] = wdata1;
        else if (BYPASS != 0 && wv0 && waddr0 == ra)
          rdata[k*DATA_WIDTH +: DATA_WIDTH] = wdata0;
        else
          rdata[k*DATA_WIDTH +: DATA_WIDTH] = mem[ra];
      end
    end
  end

  always_comb begin
    busy_nxt  = busy_vec;
    rsv_ready = 1'b0;
    if (rsv_valid && in_range(rsv_addr)) rsv_ready = !busy_vec[rsv_addr];
    if (wv0) busy_nxt[waddr0] = 1'b0;
    if (wv1) busy_nxt[waddr1] = 1'b0;
    // Reserve is applied after the write clears, so it wins on the same register.
    if (rsv_ready && writable(rsv_addr)) busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      busy_vec <= '0;
      conflict <= 1'b0;
    end else begin
      if (wv0) mem[waddr0] <= wdata0;
      if (wv1) mem[waddr1] <= wdata1;
      busy_vec <= busy_nxt;
      conflict <= we0 && we1 && (waddr0 == waddr1) && in_range(waddr0);
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb across three configurations sharing one stimulus stream.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        we0, we1, rsv_valid;
  logic [2:0]  waddr0, waddr1, rsv_addr;
  logic [15:0] wdata0, wdata1;
  logic [5:0]  raddr;

  logic [31:0] rdata_a, rdata_z, rdata_s;
  logic [1:0]  rbusy_a, rbusy_z, rbusy_s;
  logic        rdy_a, rdy_z, rdy_s;
  logic [7:0]  busy_a, busy_z;
  logic [5:0]  busy_s;
  logic        conf_a, conf_z, conf_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // a: default config; z: zero register; s: 6 registers without bypass
  reg_file_sb #(.NUM_REGS(8), .ZERO_REG(0), .BYPASS(1)) u_a (
    .clk(clk), .reset(reset), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .raddr(raddr), .rdata(rdata_a),
    .rbusy(rbusy_a), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rdy_a),
    .busy_vec(busy_a), .conflict(conf_a));

  reg_file_sb #(.NUM_REGS(8), .ZERO_REG(1), .BYPASS(1)) u_z (
    .clk(clk), .reset(reset), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .raddr(raddr), .rdata(rdata_z),
    .rbusy(rbusy_z), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rdy_z),
    .busy_vec(busy_z), .conflict(conf_z));

  reg_file_sb #(.NUM_REGS(6), .ZERO_REG(0), .BYPASS(0)) u_s (
    .clk(clk), .reset(reset), .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .raddr(raddr), .rdata(rdata_s),
    .rbusy(rbusy_s), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rdy_s),
    .busy_vec(busy_s), .conflict(conf_s));

  localparam int A_RD0 = 0, A_RD1 = 1, A_RBUSY = 2, A_BUSY = 3, A_RDY = 4, A_CONF = 5;
  localparam int Z_RD0 = 10, Z_BUSY = 13, Z_RDY = 14;
  localparam int S_RD0 = 20, S_RD1 = 21, S_RBUSY = 22, S_BUSY = 23, S_RDY = 24, S_CONF = 25;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      A_RD0:   return {16'h0, rdata_a[15:0]};
      A_RD1:   return {16'h0, rdata_a[31:16]};
      A_RBUSY: return {30'h0, rbusy_a};
      A_BUSY:  return {24'h0, busy_a};
      A_RDY:   return {31'h0, rdy_a};
      A_CONF:  return {31'h0, conf_a};
      Z_RD0:   return {16'h0, rdata_z[15:0]};
      Z_BUSY:  return {24'h0, busy_z};
      Z_RDY:   return {31'h0, rdy_z};
      S_RD0:   return {16'h0, rdata_s[15:0]};
      S_RD1:   return {16'h0, rdata_s[31:16]};
      S_RBUSY: return {30'h0, rbusy_s};
      S_BUSY:  return {26'h0, busy_s};
      S_RDY:   return {31'h0, rdy_s};
      S_CONF:  return {31'h0, conf_s};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sbq.push_back(e);
  endtask

  // Inputs are driven just after the falling edge; outputs are sampled 2 time units later.
  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    #2;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observe(e.sel);
      total++;
      assert (obs === e.exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic idle();
    we0 = 1'b0; waddr0 = '0; wdata0 = '0;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0;
    rsv_valid = 1'b0; rsv_addr = '0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    raddr = '0;
    tick();
    tick();

    reset = 1'b0;
    push("rst_rdata", A_RD0, 32'h0);
    push("rst_busy_a", A_BUSY, 32'h0);
    push("rst_conf", A_CONF, 32'h0);
    push("rst_busy_s", S_BUSY, 32'h0);
    push("rst_rbusy", A_RBUSY, 32'h0);
    drain();
    tick();

    we0 = 1'b1; waddr0 = 3'd3; wdata0 = 16'h1234; raddr = {3'd3, 3'd3};
    push("bypass_p0", A_RD0, 32'h1234);
    push("bypass_p1", A_RD1, 32'h1234);
    push("nobypass_old", S_RD0, 32'h0);
    drain();
    tick();

    idle();
    push("wr_p0", A_RD0, 32'h1234);
    push("wr_p1", A_RD1, 32'h1234);
    push("wr_nobypass", S_RD0, 32'h1234);
    push("wr_zero_cfg", Z_RD0, 32'h1234);
    drain();
    tick();

    we0 = 1'b1; waddr0 = 3'd5; wdata0 = 16'hAAAA;
    we1 = 1'b1; waddr1 = 3'd5; wdata1 = 16'h5555; raddr = {3'd5, 3'd5};
    push("conf_bypass_pri", A_RD0, 32'h5555);
    push("conf_before", A_CONF, 32'h0);
    drain();
    tick();

    idle();
    push("conf_data", A_RD0, 32'h5555);
    push("conf_data_s", S_RD1, 32'h5555);
    push("conf_high", A_CONF, 32'h1);
    push("conf_high_s", S_CONF, 32'h1);
    drain();
    tick();

    we0 = 1'b1; waddr0 = 3'd0; wdata0 = 16'hFFFF;
    rsv_valid = 1'b1; rsv_addr = 3'd0; raddr = {3'd0, 3'd0};
    push("conf_drop", A_CONF, 32'h0);
    push("zr_rdy", Z_RDY, 32'h1);
    push("zr_read_bypass", Z_RD0, 32'h0);
    push("r0_bypass_a", A_RD0, 32'hFFFF);
    push("r0_rdy_a", A_RDY, 32'h1);
    drain();
    tick();

    idle();
    push("zr_read", Z_RD0, 32'h0);
    push("zr_busy", Z_BUSY, 32'h0);
    push("wr_rsv_r0_busy", A_BUSY, 32'h01);
    push("wr_rsv_r0_data", A_RD0, 32'hFFFF);
    push("rbusy_r0", A_RBUSY, 32'h3);
    drain();
    tick();

    we0 = 1'b1; waddr0 = 3'd0; wdata0 = 16'h0000;
    push("busy_pre_edge", A_BUSY, 32'h01);
    push("rbusy_no_bypass", A_RBUSY, 32'h3);
    push("r0_bypass_clr", A_RD0, 32'h0);
    drain();
    tick();

    idle();
    rsv_valid = 1'b1; rsv_addr = 3'd2; raddr = {3'd2, 3'd2};
    push("rsv2_rdy", A_RDY, 32'h1);
    push("rsv2_busy_pre", A_BUSY, 32'h0);
    drain();
    tick();

    push("rsv2_busy", A_BUSY, 32'h04);
    push("rsv2_again_rdy", A_RDY, 32'h0);
    push("rsv2_rbusy", A_RBUSY, 32'h3);
    drain();
    tick();

    idle();
    we0 = 1'b1; waddr0 = 3'd2; wdata0 = 16'h0042;
    push("wr2_busy_pre", A_BUSY, 32'h04);
    drain();
    tick();

    idle();
    push("wr2_busy_clr", A_BUSY, 32'h0);
    push("wr2_data", A_RD0, 32'h0042);
    push("wr2_rbusy", A_RBUSY, 32'h0);
    drain();
    tick();

    we0 = 1'b1; waddr0 = 3'd6; wdata0 = 16'hBEEF;
    rsv_valid = 1'b1; rsv_addr = 3'd6;
    push("wr_rsv6_rdy", A_RDY, 32'h1);
    push("oor6_rdy_s", S_RDY, 32'h0);
    drain();
    tick();

    idle();
    rsv_valid = 1'b1; rsv_addr = 3'd1; raddr = {3'd6, 3'd6};
    push("wr_rsv6_busy", A_BUSY, 32'h40);
    push("wr_rsv6_data", A_RD0, 32'hBEEF);
    push("oor6_data_s", S_RD0, 32'h0);
    push("oor6_rbusy_s", S_RBUSY, 32'h0);
    drain();
    tick();

    idle();
    we1 = 1'b1; waddr1 = 3'd7; wdata1 = 16'h7777;
    rsv_valid = 1'b1; rsv_addr = 3'd7; raddr = {3'd7, 3'd1};
    push("oor7_rdy_s", S_RDY, 32'h0);
    push("oor7_read_s", S_RD1, 32'h0);
    push("oor7_rbusy_s", S_RBUSY, 32'h1);
    push("rsv1_busy_s", S_BUSY, 32'h02);
    push("r7_rdy_a", A_RDY, 32'h1);
    drain();
    tick();

    idle();
    push("oor7_busy_s", S_BUSY, 32'h02);
    push("oor7_read_s2", S_RD1, 32'h0);
    push("r7_busy_a", A_BUSY, 32'hC2);
    push("r7_data_a", A_RD1, 32'h7777);
    drain();
    reset = 1'b1;
    we0 = 1'b1; waddr0 = 3'd4; wdata0 = 16'h1111;
    rsv_valid = 1'b1; rsv_addr = 3'd3;
    tick();

    reset = 1'b0;
    idle();
    raddr = {3'd6, 3'd3};
    push("mid_rst_busy_a", A_BUSY, 32'h0);
    push("mid_rst_busy_s", S_BUSY, 32'h0);
    push("mid_rst_r3_a", A_RD0, 32'h0);
    push("mid_rst_r6_a", A_RD1, 32'h0);
    push("mid_rst_r3_s", S_RD0, 32'h0);
    push("mid_rst_conf", A_CONF, 32'h0);
    drain();
    raddr = {3'd4, 3'd4};
    push("mid_rst_r4_a", A_RD0, 32'h0);
    drain();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-port register file for the simple CPU datapath. It has a configurable number of combinational read ports and two synchronous write ports with fixed priority. Optional write-to-read bypass and an optional hardwired zero register are selected by parameter. A per-register scoreboard (busy bits with a reserve handshake) lets the control FSM stall on registers with an outstanding write from the 74181 ALU path or the load path.

## Interface
Parameters:
- DATA_WIDTH, 16, data width of every register.
- NUM_REGS, 8, number of registers; must be at least 2.
- ADDR_WIDTH, $clog2(NUM_REGS), address width.
- NUM_RD, 2, number of read ports; 1 to 4.
- ZERO_REG, 0, when 1, register 0 always reads 0, ignores writes and is never busy.
- BYPASS, 1, when 1, a read of an address being written this cycle returns the write data.

Ports (clock and reset first):
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- we0  in  1  write enable, port 0.
- waddr0  in  ADDR_WIDTH  write address, port 0.
- wdata0  in  DATA_WIDTH  write data, port 0.
- we1  in  1  write enable, port 1; port 1 has priority over port 0.
- waddr1  in  ADDR_WIDTH  write address, port 1.
- wdata1  in  DATA_WIDTH  write data, port 1.
- raddr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port k is bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NUM_RD*DATA_WIDTH  packed read data, same packing as raddr.
- rbusy  out  NUM_RD  busy bit of each read port's addressed register.
- rsv_valid  in  1  reserve request.
- rsv_addr  in  ADDR_WIDTH  register to reserve.
- rsv_ready  out  1  reservation accepted this cycle.
- busy_vec  out  NUM_REGS  scoreboard bits, bit i is register i.
- conflict  out  1  registered one-cycle flag: both write ports hit the same register.

## Operation
- Storage: NUM_REGS x DATA_WIDTH registers.
- Reset: all registers 0, busy_vec 0, conflict 0.
- Write: on the clock edge with we0 or we1 set, the addressed register takes the write data.
  - If both ports are enabled and waddr0 == waddr1, the register takes wdata1 and conflict is 1 for the next cycle.
  - An address >= NUM_REGS is ignored.
  - With ZERO_REG=1, an address of 0 is ignored.
- Read (combinational, per port k):
  - An address >= NUM_REGS gives 0.
  - With ZERO_REG=1, an address of 0 gives 0.
  - With BYPASS=1, a match on an enabled, valid write port gives that port's data, with port 1 checked first.
  - Otherwise the stored value is returned.
- rbusy[k] = busy_vec[raddr_k], or 0 for an out-of-range address.
  - Bypass does not affect rbusy; it shows the state before the edge.
- Scoreboard:
  - rsv_ready = rsv_valid && rsv_addr < NUM_REGS && !busy_vec[rsv_addr].
  - This uses the current busy bits only; a release in the same cycle is not forwarded.
  - On an accepted reserve, busy_vec[rsv_addr] is set at the next edge.
  - A valid write to register i clears busy_vec[i] at the edge.
  - A write and an accepted reserve to the same register in the same cycle: the data is stored and the busy bit ends up set (reserve wins).
  - With ZERO_REG=1, a reserve of register 0 is accepted (rsv_ready=1) but its busy bit is never set.
- reset asserted mid-operation overrides all writes and reserves in that cycle.

## Timing
- Read latency 0: rdata and rbusy are combinational from raddr, the stored state and, with BYPASS, the write inputs.
- Write latency 1: without BYPASS, data written at edge N is visible on rdata after edge N.
- rsv_ready is combinational; busy_vec and rbusy reflect an accepted reserve one cycle later.
- conflict is high for exactly one cycle after the conflicting edge, and 0 in the cycle after reset.
- Outputs after reset: rdata 0, except bypassed write data; rbusy 0; busy_vec 0; conflict 0; rsv_ready as its equation gives.

## Test plan
- Reset, then write 0x1234 to r3 via port 0, then read r3 on both ports -> 0x1234 next cycle; with BYPASS=1, rdata shows 0x1234 in the write cycle itself.
- Same cycle: we0 r5=0xAAAA and we1 r5=0x5555 -> r5 reads 0x5555; conflict=1 for one cycle, then 0.
- ZERO_REG=1: write 0xFFFF to r0 and reserve r0 -> r0 reads 0, rsv_ready=1, busy_vec[0] stays 0.
- Reserve r2 -> busy_vec=0x04 next cycle; a second reserve of r2 gets rsv_ready=0; write 0x0042 to r2 -> busy cleared and r2=0x0042.
- Write and reserve r6 in the same cycle -> r6 holds the data and busy_vec[6]=1.
- NUM_REGS=6: write to address 7 and read address 7 -> no state change, rdata=0, rsv_ready=0; assert reset with busy bits set -> all busy bits and registers are 0 after the edge.
